// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave that maps a 1 KiB window onto port 0 (1RW) of the
// 32x256 OpenRAM macro. It issues one registered SRAM access per bus cycle,
// waits out the macro read latency, and acks for exactly one cycle.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00,
  parameter int unsigned SRAM_AW   = 8,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               sram_csb0_o,
  output logic               sram_web0_o,
  output logic [3:0]         sram_wmask0_o,
  output logic [SRAM_AW-1:0] sram_addr0_o,
  output logic [31:0]        sram_din0_o,
  input  logic [31:0]        sram_dout0_i,
  output logic               busy_o
);

  // READ_LAT is limited to 1..3, so a 2-bit down-counter covers it.
  localparam int unsigned    CNT_W    = 2;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RWAIT = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic             hit_c;

  // Window decode: a live strobe whose masked address matches the base.
  assign hit_c = wbs_cyc_i & wbs_stb_i &
                 ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

  // Bridge FSM with all bus and SRAM outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state         <= ST_IDLE;
      lat_cnt       <= '0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      sram_csb0_o   <= 1'b1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= '0;
      sram_addr0_o  <= '0;
      sram_din0_o   <= '0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit_c) begin
            sram_addr0_o  <= wbs_adr_i[SRAM_AW+1:2];
            sram_din0_o   <= wbs_dat_i;
            sram_wmask0_o <= wbs_we_i ? wbs_sel_i : 4'b0000;
            sram_web0_o   <= ~wbs_we_i;
            sram_csb0_o   <= 1'b0;
            busy_o        <= 1'b1;
            state         <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // The macro samples this cycle's controls; deselect afterwards.
          // web0 still holds the operation type during this cycle.
          sram_csb0_o <= 1'b1;
          sram_web0_o <= 1'b1;
          if (!wbs_cyc_i) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (!sram_web0_o) begin
            wbs_ack_o <= 1'b1;
            state     <= ST_ACK;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= ST_RWAIT;
          end
        end

        ST_RWAIT: begin
          // An abort wins over a capture due in the same cycle.
          if (!wbs_cyc_i) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (lat_cnt == CNT_W'(1)) begin
            wbs_dat_o <= sram_dout0_i;
            wbs_ack_o <= 1'b1;
            state     <= ST_ACK;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          wbs_ack_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: two instances (read latency 1 and 3), each with
// its own SRAM model, transaction-level reference and per-cycle compare.
module tb_wb_sram_bridge;

  localparam int unsigned AW   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FC00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Deterministic power-up contents shared by the SRAM model and the reference.
  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    logic          rst_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   adr = '0, dat_i = '0;
    logic          ack, csb, web, busy;
    logic [31:0]   dat_o, din;
    logic [31:0]   dout = '0;
    logic [3:0]    wmask;
    logic [AW-1:0] addr;

    wb_sram_bridge #(
      .BASE_ADDR(BASE), .ADDR_MASK(MASK), .SRAM_AW(AW), .READ_LAT(LAT)
    ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask),
      .sram_addr0_o(addr), .sram_din0_o(din), .sram_dout0_i(dout),
      .busy_o(busy)
    );

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    // SRAM macro model: garbage on dout until LAT edges after a read sample.
    logic [31:0] smem [256];
    bit          sm_init = 1'b0;
    int          rcnt = 0;
    logic [31:0] rdata = '0;
    always @(posedge clk) begin
      if (!sm_init) begin
        for (int i = 0; i < 256; i++) smem[i] = init_word(i);
        sm_init = 1'b1;
      end
      if (rcnt > 1) begin
        rcnt = rcnt - 1;
        dout <= $urandom;
      end else if (rcnt == 1) begin
        rcnt = 0;
        dout <= rdata;
      end
      if (!csb) begin
        if (!web) begin
          for (int b = 0; b < 4; b++)
            if (wmask[b]) smem[addr][8*b +: 8] = din[8*b +: 8];
        end else if (LAT == 1) begin
          dout <= smem[addr];
        end else begin
          rdata = smem[addr];
          rcnt  = int'(LAT) - 1;
          dout <= $urandom;
        end
      end
    end

    // Reference model: memory image plus expected per-cycle output schedule.
    logic [31:0]   mmem [256];
    int            exp_issue = -1, exp_ack = -1, busy_lo = -1, busy_hi = -2;
    logic          exp_web = 1'b1;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   exp_din = '0;
    logic [3:0]    exp_mask = '0;
    logic [31:0]   dat_cur = '0, dat_new = '0;
    int            dat_at = -1;
    int            ack_seen = 0;
    bit            armed = 1'b0;
    bit            fin = 1'b0;

    function automatic string nm(string s);
      return $sformatf("L%0d %s cyc%0d", LAT, s, cnt);
    endfunction

    // Per-cycle comparison of every output against the model schedule.
    always @(negedge clk) begin : cmp
      logic [31:0] ed;
      ed = (dat_at >= 0 && cnt >= dat_at) ? dat_new : dat_cur;
      if (armed) begin
        chk(nm("ack"),   32'(ack),  32'(cnt == exp_ack));
        chk(nm("csb0"),  32'(csb),  32'(cnt != exp_issue));
        chk(nm("web0"),  32'(web),  32'((cnt == exp_issue) ? exp_web : 1'b1));
        chk(nm("busy"),  32'(busy), 32'(cnt >= busy_lo && cnt <= busy_hi));
        chk(nm("dat_o"), dat_o, ed);
        if (cnt == exp_issue) begin
          chk(nm("addr0"),  32'(addr),  32'(exp_addr));
          chk(nm("din0"),   din,        exp_din);
          chk(nm("wmask0"), 32'(wmask), 32'(exp_mask));
        end
      end
    end

    always @(negedge clk) if (ack === 1'b1) ack_seen <= ack_seen + 1;

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic chk_reset_vals(string tag);
      chk(nm({tag, " ack"}),    32'(ack),   32'd0);
      chk(nm({tag, " dat_o"}),  dat_o,      32'd0);
      chk(nm({tag, " csb0"}),   32'(csb),   32'd1);
      chk(nm({tag, " web0"}),   32'(web),   32'd1);
      chk(nm({tag, " wmask0"}), 32'(wmask), 32'd0);
      chk(nm({tag, " addr0"}),  32'(addr),  32'd0);
      chk(nm({tag, " din0"}),   din,        32'd0);
      chk(nm({tag, " busy"}),   32'(busy),  32'd0);
    endtask

    // Drive a hit request now and schedule what the outputs must do.
    task automatic begin_xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, input int abort_at, output int ack_c);
      int c0;
      int idx;
      c0 = cnt;
      if (dat_at >= 0 && c0 >= dat_at) begin
        dat_cur = dat_new;
        dat_at  = -1;
      end
      idx = int'(a[9:2]);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
      exp_issue = c0 + 1;
      exp_web   = !w;
      exp_addr  = a[9:2];
      exp_din   = d;
      exp_mask  = w ? s : 4'b0000;
      ack_c     = w ? c0 + 2 : c0 + 2 + int'(LAT);
      busy_lo   = c0 + 1;
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) mmem[idx][8*b +: 8] = d[8*b +: 8];
      if (abort_at > 0) begin
        exp_ack = -1;
        busy_hi = c0 + abort_at;
      end else begin
        exp_ack = ack_c;
        busy_hi = ack_c;
        if (!w) begin
          dat_new = mmem[idx];
          dat_at  = ack_c;
        end
      end
    endtask

    // One bus cycle; returns at the start of the first cycle the bus is free.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_at, input int miss_hold);
      int c0;
      int ack_c;
      if ((a & MASK) != (BASE & MASK)) begin
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        repeat (miss_hold) tick();
        cyc = 1'b0; stb = 1'b0;
        return;
      end
      c0 = cnt;
      begin_xfer(w, a, s, d, abort_at, ack_c);
      if (abort_at > 0) begin
        repeat (abort_at) tick();
        cyc = 1'b0; stb = 1'b0;
        tick();
      end else begin
        repeat (ack_c - c0 + 1) tick();
        cyc = 1'b0; stb = 1'b0;
      end
    endtask

    initial begin : stim
      int a0, c_s, c0, ack_c;
      logic [31:0] ra;
      bit rw;
      for (int i = 0; i < 256; i++) mmem[i] = init_word(i);

      // Power-up reset
      rst_n = 1'b0;
      tick(); tick();
      chk_reset_vals("por");
      rst_n = 1'b1;
      armed = 1'b1;
      tick();

      // Write then read back
      xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 0, 0);
      chk(nm("wr addr0"), 32'(addr), 32'h04);
      chk(nm("wr wmask0"), 32'(wmask), 32'hF);
      xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0, 0);
      chk(nm("rd dat_o"), dat_o, 32'hDEAD_BEEF);
      chk(nm("model rd"), dat_new, 32'hDEAD_BEEF);

      // Byte-masked write over all-ones
      xfer(1'b1, 32'h3000_0020, 4'hF, 32'hFFFF_FFFF, 0, 0);
      xfer(1'b1, 32'h3000_0020, 4'b0101, 32'h1122_3344, 0, 0);
      chk(nm("mask wmask0"), 32'(wmask), 32'h5);
      xfer(1'b0, 32'h3000_0020, 4'hF, 32'h0, 0, 0);
      chk(nm("mask rd"), dat_o, 32'hFF22_FF44);
      chk(nm("model mask"), mmem[8], 32'hFF22_FF44);

      // Window miss just past the top
      a0 = ack_seen;
      xfer(1'b0, 32'h3000_0400, 4'hF, 32'h0, 0, 10);
      chk(nm("miss acks"), 32'(ack_seen - a0), 32'd0);
      tick();

      // Last word of the window, then a zero-select write to it
      xfer(1'b1, 32'h3000_03FC, 4'hF, 32'hA5A5_0FF0, 0, 0);
      chk(nm("top addr0"), 32'(addr), 32'hFF);
      xfer(1'b1, 32'h3000_03FD, 4'h0, 32'h1234_5678, 0, 0);
      chk(nm("sel0 wmask0"), 32'(wmask), 32'h0);
      xfer(1'b0, 32'h3000_03FC, 4'hF, 32'h0, 0, 0);
      chk(nm("sel0 rd"), dat_o, 32'hA5A5_0FF0);

      // Read aborted in its last wait cycle, then a normal read
      a0 = ack_seen;
      xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, int'(LAT) + 1, 0);
      chk(nm("abort acks"), 32'(ack_seen - a0), 32'd0);
      chk(nm("abort dat_o"), dat_o, 32'hA5A5_0FF0);
      xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0, 0);
      chk(nm("post-abort rd"), dat_o, 32'hDEAD_BEEF);

      // Write aborted in ISSUE still lands in the SRAM
      xfer(1'b1, 32'h3000_0030, 4'hF, 32'hCAFE_F00D, 1, 0);
      xfer(1'b0, 32'h3000_0030, 4'hF, 32'h0, 0, 0);
      chk(nm("abort wr rd"), dat_o, 32'hCAFE_F00D);

      // Eight back-to-back writes
      a0  = ack_seen;
      c_s = cnt;
      for (int i = 0; i < 8; i++)
        xfer(1'b1, 32'h3000_0100 + 32'(4 * i), 4'hF, $urandom, 0, 0);
      chk(nm("b2b acks"), 32'(ack_seen - a0), 32'd8);
      chk(nm("b2b cycles"), 32'(cnt - c_s), 32'd24);

      // Reset held two edges in the middle of a read
      c0 = cnt;
      begin_xfer(1'b0, 32'h3000_0020, 4'hF, 32'h0, 0, ack_c);
      tick(); tick();
      rst_n   = 1'b0;
      exp_ack = -1;
      busy_hi = c0 + 2;
      dat_new = 32'h0;
      dat_at  = c0 + 3;
      tick();
      cyc = 1'b0; stb = 1'b0;
      chk_reset_vals("midrst");
      tick();
      rst_n = 1'b1;
      a0 = ack_seen;
      repeat (6) tick();
      chk(nm("midrst acks"), 32'(ack_seen - a0), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
        rw = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0)
          ra = $urandom | 32'h0000_0400;
        else
          ra = BASE | 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 9) == 0)
          xfer(rw, ra, 4'($urandom), $urandom,
               rw ? 1 : int'($urandom_range(1, LAT + 1)), 0);
        else
          xfer(rw, ra, 4'($urandom), $urandom, 0, int'($urandom_range(1, 3)));
        repeat ($urandom_range(0, 2)) tick();
      end
      repeat (4) tick();
      fin = 1'b1;
    end
  end

  initial begin : summary
    for (int i = 0; i < 60000 && !(g_lat[0].fin && g_lat[1].fin); i++) @(posedge clk);
    chk("run completes", 32'(g_lat[0].fin && g_lat[1].fin), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
